// File: rtl/m_axis_ppf_channel_tx_if.sv
// AXI4-Stream bus carrying serialised polyphase filter channel samples.
//   M_TDATA  : channel sample (signed, passed through unchanged)
//   M_TUSER  : channel index 0..7 of the current beat
//   M_TVALID : beat valid
//   M_TLAST  : asserted on the channel-7 beat only
//   M_TREADY : downstream ready
interface m_axis_ppf_channel_tx_if #(
  parameter int unsigned TDATA_WIDTH = 64
);
  logic [TDATA_WIDTH-1:0] M_TDATA;
  logic [2:0]             M_TUSER;
  logic                   M_TVALID;
  logic                   M_TLAST;
  logic                   M_TREADY;

  modport master (
    output M_TDATA,
    output M_TUSER,
    output M_TVALID,
    output M_TLAST,
    input  M_TREADY
  );

  modport slave (
    input  M_TDATA,
    input  M_TUSER,
    input  M_TVALID,
    input  M_TLAST,
    output M_TREADY
  );
endinterface

// File: rtl/m_axis_ppf_channel_tx.sv
// Serialises eight parallel filter-bank channel outputs onto one AXI4-Stream.
// Each strobed frame is captured into a two-slot buffer and emitted as eight
// beats, channel 0 first, TLAST on channel 7. Frames arriving while both
// slots are occupied are dropped and flagged on the sticky overflow_o.
//   ACLK, ARESETn        : clock, asynchronous active-low reset
//   channelN_data_i      : channel samples of one filter output frame
//   frame_valid_i        : one-cycle strobe qualifying the channel inputs
//   frame_ready_o        : a buffer slot is free
//   overflow_o           : sticky, a frame was dropped since reset
//   m_axis               : output stream (master modport)
module m_axis_ppf_channel_tx #(
  parameter int unsigned TDATA_WIDTH = 64
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [TDATA_WIDTH-1:0] channel0_data_i,
  input  logic [TDATA_WIDTH-1:0] channel1_data_i,
  input  logic [TDATA_WIDTH-1:0] channel2_data_i,
  input  logic [TDATA_WIDTH-1:0] channel3_data_i,
  input  logic [TDATA_WIDTH-1:0] channel4_data_i,
  input  logic [TDATA_WIDTH-1:0] channel5_data_i,
  input  logic [TDATA_WIDTH-1:0] channel6_data_i,
  input  logic [TDATA_WIDTH-1:0] channel7_data_i,
  input  logic                   frame_valid_i,
  output logic                   frame_ready_o,
  output logic                   overflow_o,
  m_axis_ppf_channel_tx_if.master m_axis
);

  typedef enum logic {IDLE, SEND} state_t;

  logic [TDATA_WIDTH-1:0] chan_in [8];
  logic [TDATA_WIDTH-1:0] slot_q  [2][8];

  state_t                 state_q, state_d;
  logic [2:0]             ch_idx_q, ch_idx_d, ch_next;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [2:0]             tuser_q, tuser_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [1:0]             count_q, count_d;
  logic                   wr_ptr_q, rd_ptr_q;
  logic                   overflow_q;
  logic                   capture, drop, release_slot, handshake;

  assign chan_in[0] = channel0_data_i;
  assign chan_in[1] = channel1_data_i;
  assign chan_in[2] = channel2_data_i;
  assign chan_in[3] = channel3_data_i;
  assign chan_in[4] = channel4_data_i;
  assign chan_in[5] = channel5_data_i;
  assign chan_in[6] = channel6_data_i;
  assign chan_in[7] = channel7_data_i;

  // Room is judged on the registered count only; a release on the same
  // edge does not make space for an incoming frame.
  assign capture   = frame_valid_i && (count_q != 2'd2);
  assign drop      = frame_valid_i && (count_q == 2'd2);
  assign handshake = tvalid_q && m_axis.M_TREADY;
  assign ch_next   = ch_idx_q + 3'd1;

  // Frame storage carries no reset: contents are only read once count says
  // the slot has been written.
  always_ff @(posedge ACLK) begin
    if (capture) begin
      for (int unsigned i = 0; i < 8; i++) begin
        slot_q[wr_ptr_q][3'(i)] <= chan_in[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ch_idx_d     = ch_idx_q;
    tdata_d      = tdata_q;
    tuser_d      = tuser_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    release_slot = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          tdata_d  = slot_q[rd_ptr_q][3'd0];
          tuser_d  = 3'd0;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          ch_idx_d = 3'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (ch_idx_q != 3'd7) begin
            tdata_d  = slot_q[rd_ptr_q][ch_next];
            tuser_d  = ch_next;
            tlast_d  = (ch_next == 3'd7);
            ch_idx_d = ch_next;
          end else begin
            release_slot = 1'b1;
            tlast_d      = 1'b0;
            ch_idx_d     = 3'd0;
            // A second queued frame follows with no bubble; a frame
            // captured on this same edge waits for the IDLE pass.
            if (count_q == 2'd2) begin
              tdata_d = slot_q[~rd_ptr_q][3'd0];
              tuser_d = 3'd0;
            end else begin
              tvalid_d = 1'b0;
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({capture, release_slot})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      ch_idx_q   <= '0;
      tdata_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      count_q  <= count_d;
      if (capture)      wr_ptr_q   <= ~wr_ptr_q;
      if (release_slot) rd_ptr_q   <= ~rd_ptr_q;
      if (drop)         overflow_q <= 1'b1;
    end
  end

  assign frame_ready_o   = (count_q != 2'd2);
  assign overflow_o      = overflow_q;
  assign m_axis.M_TDATA  = tdata_q;
  assign m_axis.M_TUSER  = tuser_q;
  assign m_axis.M_TVALID = tvalid_q;
  assign m_axis.M_TLAST  = tlast_q;

endmodule

// File: doc/m_axis_ppf_channel_tx.md
# m_axis_ppf_channel_tx

AXI4-Stream master that serialises the eight parallel 64-bit channel outputs of the direct-form polyphase filter bank onto a single output stream. Each filter output frame (channel 0..7 sampled together) is captured into a two-slot frame buffer and emitted as eight consecutive beats, channel 0 first, with TLAST on channel 7. It sits after `s_axis_direct_ppf` and drives downstream consumers such as the DMA or FFT stage. It honours backpressure and flags dropped frames.

## Interface
- TDATA_WIDTH, 64, width of each channel sample and of M_TDATA; samples are signed two's complement and pass through unchanged.
- ACLK  in  1  single clock; all logic on rising edge.
- ARESETn  in  1  reset, asynchronous and active-low.
- channel0_data_i .. channel7_data_i  in  TDATA_WIDTH each  channel samples of one filter output frame.
- frame_valid_i  in  1  one-cycle strobe; channel inputs are valid in this cycle.
- frame_ready_o  out  1  high when a free buffer slot exists (count != 2); combinational from registered count.
- M_TDATA  out  TDATA_WIDTH  current beat sample.
- M_TUSER  out  3  channel index of current beat (0..7).
- M_TVALID  out  1  beat valid.
- M_TLAST  out  1  high on channel-7 beat only.
- M_TREADY  in  1  downstream ready.
- overflow_o  out  1  sticky: a frame strobe arrived while the buffer was full.

## Operation
- Buffer: 2 slots × 8 samples; wr_ptr, rd_ptr (1 bit each), count (0..2).
- Capture: at an edge with frame_valid_i=1 and count<2, all eight inputs are written to slot[wr_ptr]; wr_ptr toggles; count increments.
- Drop: frame_valid_i=1 with count==2 → frame discarded, buffer untouched, overflow_o set to 1 until reset. A capture decision uses registered count only; a release on the same edge does not free room for it.
- FSM states IDLE, SEND; beat index ch_idx (3 bits).
  - IDLE: if count!=0, load slot[rd_ptr][0] into the output registers, M_TUSER=0, M_TVALID=1, ch_idx=0, go to SEND.
  - SEND, handshake on beat ch_idx<7: load beat ch_idx+1 on the same edge, with no bubble. M_TLAST=1 when the loaded index is 7.
  - SEND, handshake on beat 7: release the slot (rd_ptr toggles, count decrements). If count==2 before release, load beat 0 of the next slot on the same edge and stay in SEND. Otherwise M_TVALID=0 and go to IDLE.
  - Simultaneous capture and release: count is unchanged. If count was 1, the FSM still goes to IDLE, which gives a one-cycle bubble before the new frame.
- AXIS rules: once M_TVALID=1, M_TDATA, M_TUSER and M_TLAST hold stable until the handshake edge. M_TVALID never deasserts without a handshake. M_TVALID does not depend on M_TREADY.

## Timing
- Reset (async, immediate): M_TVALID=0, M_TLAST=0, M_TDATA=0, M_TUSER=0, overflow_o=0, count=0, pointers=0, FSM=IDLE. frame_ready_o=1.
- Reset asserted mid-frame: outputs clear at once and buffered frames are lost. After deassertion the next captured frame starts at channel 0.
- Latency: strobe sampled at edge E0 with the buffer empty → M_TVALID=1 with channel 0 after edge E0+1.
- Throughput with M_TREADY held high: 8 beats in 8 cycles. Frames already queued run back to back with no bubble.
- frame_ready_o falls in the cycle after the second frame is captured. It rises in the cycle after the first frame's TLAST handshake.

## Test plan
- Reset: hold ARESETn=0 and toggle inputs → all outputs 0, frame_ready_o=1. Assert ARESETn mid-SEND → M_TVALID drops without waiting for a clock.
- Single frame: channelN_data_i = 64'h1000_0000_0000_000N, M_TREADY=1, strobe at E0 → beats 0..7 after E0+1..E0+8, M_TUSER=0..7, M_TLAST only on beat 7, M_TVALID=0 after E0+9.
- Backpressure: M_TREADY pattern 1,0,0,1,0,1,1,0,… → 8 beats in order. M_TDATA, M_TUSER and M_TLAST are stable through every stall. The count of M_TREADY=1 cycles while M_TVALID=1 equals 8.
- Full/overflow: M_TREADY=0, three strobes 2 cycles apart with distinct data (signed negatives included, e.g. -1, -2^63) → frame_ready_o=0 after the 2nd. The 3rd is dropped and overflow_o=1 stays set. Then M_TREADY=1 → 16 beats, frames 1 then 2, with no idle cycle between beat 7 and the next beat 0.
- Simultaneous: count=1, strobe on the same edge as the TLAST handshake → accepted. One M_TVALID=0 cycle follows, then the new frame's 8 beats. overflow_o stays 0.
- Reset recovery: reset during beat 3 of a frame, release, strobe a new frame → the output starts at M_TUSER=0 with the new data, and no stale beats appear.
